// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with runtime data length, parity, stop bits and baud divisor.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          i_tx_clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_data_valid,
    output logic                          o_data_ready,
    input  logic [3:0]                    i_len,
    input  logic                          i_parity_en,
    input  logic                          i_parity_ty,
    input  logic                          i_stop2,
    input  logic [DIV_W-1:0]              i_baud_div,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_tx_done,
    output logic                          o_tx_er,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [4:0] DW = 5'(DATA_W);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP1 = 3'd4, STOP2 = 3'd5;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [2:0]        state;
    logic [DATA_W-1:0] shreg, head;
    logic [DIV_W-1:0]  cnt, div_q, div_eff;
    logic [3:0]        bit_idx, len_q;
    logic              par_en_q, par_q, stop2_q, head_par, push, pop, tick, len_ok;

    assign head         = mem[rd_ptr];
    assign push         = i_data_valid && o_data_ready;
    assign pop          = state == IDLE && count != '0;
    assign tick         = cnt == '0;
    assign len_ok       = i_len >= 4'd5 && {1'b0, i_len} <= DW;
    assign div_eff      = i_baud_div == '0 ? DIV_W'(1) : i_baud_div;
    assign o_data_ready = count < FULL;
    assign o_busy       = state != IDLE;
    assign o_fifo_count = count;

    // Parity only covers the bits actually sent for this frame's length
    always_comb begin
        head_par = i_parity_ty;
        for (int i = 0; i < DATA_W; i++)
            head_par = head_par ^ (head[i] & (i < int'(i_len)));
    end

    always_ff @(posedge i_tx_clk)
        if (push) mem[wr_ptr] <= i_data;

    always_ff @(posedge i_tx_clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            o_tx      <= 1'b1;
            o_tx_done <= 1'b0;
            o_tx_er   <= 1'b0;
            cnt       <= '0;
            div_q     <= '0;
            bit_idx   <= '0;
            len_q     <= '0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count     <= count + (AW+1)'(push) - (AW+1)'(pop);
            o_tx_done <= 1'b0;
            o_tx_er   <= 1'b0;
            if (state != IDLE) cnt <= tick ? div_q - DIV_W'(1) : cnt - DIV_W'(1);
            case (state)
                IDLE: if (pop) begin
                    shreg    <= head;
                    len_q    <= i_len;
                    par_en_q <= i_parity_en;
                    par_q    <= head_par;
                    stop2_q  <= i_stop2;
                    div_q    <= div_eff;
                    cnt      <= div_eff - DIV_W'(1);
                    bit_idx  <= '0;
                    if (len_ok) begin
                        state <= START;
                        o_tx  <= 1'b0;
                    end else o_tx_er <= 1'b1;
                end
                START: if (tick) begin
                    state <= DATA;
                    o_tx  <= shreg[0];
                end
                DATA: if (tick) begin
                    if (bit_idx == len_q - 4'd1) begin
                        state <= par_en_q ? PARITY : STOP1;
                        o_tx  <= par_en_q ? par_q : 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        shreg   <= shreg >> 1;
                        o_tx    <= shreg[1];
                    end
                end
                PARITY: if (tick) begin
                    state <= STOP1;
                    o_tx  <= 1'b1;
                end
                STOP1: if (tick) begin
                    state     <= stop2_q ? STOP2 : IDLE;
                    o_tx_done <= !stop2_q;
                end
                STOP2: if (tick) begin
                    state     <= IDLE;
                    o_tx_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; expected frames are queued at push and checked cycle-by-cycle on o_tx.
module tb_uart_tx_fifo;
    logic        clk = 0, rst = 1;
    logic [7:0]  data = 0;
    logic        valid = 0, ready, pe = 0, pty = 0, s2 = 0;
    logic [3:0]  len = 8;
    logic [15:0] div = 4;
    logic        tx, busy, done, er;
    logic [4:0]  fcount;

    typedef struct {logic [7:0] word; int len; bit pe, pty, s2; int div;} exp_t;
    exp_t q[$];
    int   n_checks = 0, n_fail = 0, done_cnt = 0, max_cnt = 0;
    bit   saw_full = 0;

    uart_tx_fifo dut (
        .i_tx_clk(clk), .rst(rst), .i_data(data), .i_data_valid(valid), .o_data_ready(ready),
        .i_len(len), .i_parity_en(pe), .i_parity_ty(pty), .i_stop2(s2), .i_baud_div(div),
        .o_tx(tx), .o_busy(busy), .o_tx_done(done), .o_tx_er(er), .o_fifo_count(fcount)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_bit(exp_t e, int idx);
        int ones = 0;
        for (int i = 0; i < e.len; i++) ones += int'(e.word[i]);
        if (idx == 0) return 1'b0;
        if (idx <= e.len) return e.word[idx-1];
        if (idx == e.len + 1 && e.pe) return 1'(ones & 1) ^ e.pty;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (int'(fcount) > max_cnt) max_cnt = int'(fcount);
    end

    initial forever begin
        @(negedge clk);
        if (!rst && tx === 1'b0) begin
            check("queue_has_frame", q.size() != 0, 1);
            if (q.size() != 0) begin
                exp_t e;
                int dv, nb;
                bit abort;
                e = q.pop_front();
                dv = e.div == 0 ? 1 : e.div;
                nb = 2 + e.len + int'(e.pe) + int'(e.s2);
                abort = 0;
                for (int b = 0; b < nb && !abort; b++)
                    for (int k = 0; k < dv && !abort; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (rst) abort = 1;
                        else check($sformatf("tx_bit%0d", b), tx, exp_bit(e, b));
                    end
                if (!abort) begin
                    @(negedge clk);
                    if (!rst) begin
                        check("tx_done", done, 1);
                        check("idle_high", tx, 1);
                    end
                end
            end
        end
    end

    task automatic push(logic [7:0] w, bit frame);
        int t = 0;
        data = w;
        valid = 1;
        while (!ready && t < 500) begin
            saw_full = 1;
            @(negedge clk);
            t++;
        end
        check("push_ready", ready, 1);
        @(posedge clk);
        #1;
        valid = 0;
        if (frame) q.push_back('{w, int'(len), pe, pty, s2, int'(div)});
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || fcount != 0 || q.size() != 0) && t < 5000);
        check("drain_busy", busy, 0);
        check("drain_queue", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic cfg(int l, bit p, bit py, bit st2, int d);
        len = 4'(l);
        pe = p;
        pty = py;
        s2 = st2;
        div = 16'(d);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_er", er, 0);
        check("rst_count", fcount, 0);

        cfg(8, 0, 0, 0, 4); push(8'h55, 1); wait_idle();
        cfg(7, 1, 0, 1, 2); push(8'h03, 1); wait_idle();
        cfg(5, 1, 1, 0, 3); push(8'h1F, 1); wait_idle();
        cfg(6, 1, 0, 0, 0); push(8'h2D, 1); wait_idle();

        cfg(8, 1, 1, 0, 1);
        max_cnt = 0;
        saw_full = 0;
        for (int i = 0; i < 20; i++) push(8'(i * 37 + 5), 1);
        check("saw_full", saw_full, 1);
        check("count_max", max_cnt, 16);
        wait_idle();

        cfg(4, 0, 0, 0, 2);
        push(8'hA5, 0);
        begin
            int t = 0;
            bit got = 0;
            while (!got && t < 10) begin
                @(negedge clk);
                check("er_line_high", tx, 1);
                got = er;
                t++;
            end
            check("er_pulse", got, 1);
            @(negedge clk);
            check("er_one_cycle", er, 0);
            check("er_not_busy", busy, 0);
        end
        cfg(8, 0, 0, 0, 2); push(8'h3C, 1); wait_idle();

        begin
            int d0, t = 0;
            cfg(8, 0, 0, 0, 4);
            push(8'h0F, 1);
            push(8'hF0, 1);
            while (!busy && t < 20) begin @(negedge clk); t++; end
            repeat (10) @(negedge clk);
            d0 = done_cnt;
            @(posedge clk); #1 rst = 1;
            @(posedge clk); #1 rst = 0;
            @(negedge clk);
            check("rst_mid_tx", tx, 1);
            check("rst_mid_count", fcount, 0);
            check("rst_mid_busy", busy, 0);
            q.delete();
            repeat (60) @(negedge clk);
            check("rst_no_done", done_cnt, d0);
            push(8'h96, 1);
            wait_idle();
        end

        begin
            int t = 0;
            cfg(8, 0, 0, 0, 3);
            push(8'hC3, 1);
            while (!busy && t < 20) begin @(negedge clk); t++; end
            cfg(6, 1, 1, 1, 2);
            push(8'h2A, 1);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
